// File: rtl/riscv_dmem_resp_align_pkg.sv
// Shared RISC-V data-memory response constants: tag layout, load type codes,
// the aligned writeback payload and the alignment/extension helpers.
package riscv_dmem_resp_align_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned TAG_W       = 12;
  localparam int unsigned RD_W        = 5;
  localparam int unsigned TAG_FP_BIT  = 11;
  localparam int unsigned TAG_TYPE_LO = 8;
  localparam int unsigned TAG_OFF_LO  = 5;
  localparam int unsigned TAG_RD_LO   = 0;

  typedef enum logic [2:0] {
    MT_B  = 3'b000,
    MT_H  = 3'b001,
    MT_W  = 3'b010,
    MT_D  = 3'b011,
    MT_BU = 3'b100,
    MT_HU = 3'b101,
    MT_WU = 3'b110,
    MT_X  = 3'b111
  } mem_type_e;

  typedef struct packed {
    logic            fp;
    logic [RD_W-1:0] waddr;
    logic [XLEN-1:0] wdata;
  } ll_payload_t;

  // FP loads only exist as W or D; integer accesses must be naturally aligned.
  function automatic logic is_misaligned(mem_type_e t, logic [2:0] off, logic fp);
    case (t)
      MT_B, MT_BU: return fp;
      MT_H, MT_HU: return fp | off[0];
      MT_W, MT_WU: return off[1:0] != 2'd0;
      MT_D:        return off != 3'd0;
      default:     return 1'b1;
    endcase
  endfunction

  // FP W stays raw (zero-extended) so the FP unit sees the unrecoded bits.
  function automatic logic [XLEN-1:0] align_extend(mem_type_e t, logic [XLEN-1:0] data,
                                                   logic [2:0] off, logic fp);
    logic [XLEN-1:0] sh;
    sh = data >> {off, 3'b000};
    case (t)
      MT_B:    return {{56{sh[7]}}, sh[7:0]};
      MT_H:    return {{48{sh[15]}}, sh[15:0]};
      MT_W:    return fp ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      MT_D:    return sh;
      MT_BU:   return {56'd0, sh[7:0]};
      MT_HU:   return {48'd0, sh[15:0]};
      MT_WU:   return {32'd0, sh[31:0]};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_resp_fifo.sv
// Parameterised val/rdy FIFO; head is presented straight from storage.
module riscv_resp_fifo #(
  parameter int unsigned WIDTH = 70,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_val,
  output logic                     in_rdy_c,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign out_val  = count_q != '0;
  assign out_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign in_rdy_c = (count_q != CNT_W'(DEPTH)) | (out_val & out_rdy);
  assign push     = in_val & in_rdy_c;
  assign pop      = out_val & out_rdy;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/riscv_dmem_resp_align.sv
// Aligns and extends raw data-memory responses, buffers them, and presents
// them in order to writeback with sticky misalign/overflow error flags.
module riscv_dmem_resp_align
  import riscv_dmem_resp_align_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dmem_resp_val,
  input  logic [XLEN-1:0]        dmem_resp_data,
  input  logic [TAG_W-1:0]       dmem_resp_tag,
  output logic                   ll_val,
  input  logic                   ll_rdy,
  output logic [RD_W-1:0]        ll_waddr,
  output logic [XLEN-1:0]        ll_wdata,
  output logic                   ll_fp,
  output logic                   err_overflow,
  output logic                   err_misalign,
  output logic [$clog2(DEPTH):0] count
);

  mem_type_e       resp_type;
  logic [2:0]      resp_off;
  logic            resp_fp;
  logic [RD_W-1:0] resp_rd;
  logic            resp_misal;
  logic            enq_val;
  logic            enq_rdy_c;
  ll_payload_t     enq_pl;
  ll_payload_t     head_pl;
  logic            err_overflow_q, err_overflow_d;
  logic            err_misalign_q, err_misalign_d;

  assign resp_type  = mem_type_e'(dmem_resp_tag[TAG_TYPE_LO +: 3]);
  assign resp_off   = dmem_resp_tag[TAG_OFF_LO +: 3];
  assign resp_fp    = dmem_resp_tag[TAG_FP_BIT];
  assign resp_rd    = dmem_resp_tag[TAG_RD_LO +: RD_W];
  assign resp_misal = is_misaligned(resp_type, resp_off, resp_fp);
  assign enq_val    = dmem_resp_val & ~resp_misal;

  always_comb begin
    enq_pl       = '0;
    enq_pl.fp    = resp_fp;
    enq_pl.waddr = resp_rd;
    enq_pl.wdata = align_extend(resp_type, dmem_resp_data, resp_off, resp_fp);
  end

  riscv_resp_fifo #(
    .WIDTH ($bits(ll_payload_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .in_val   (enq_val),
    .in_rdy_c (enq_rdy_c),
    .in_data  (enq_pl),
    .out_val  (ll_val),
    .out_rdy  (ll_rdy),
    .out_data (head_pl),
    .count    (count)
  );

  assign ll_fp    = head_pl.fp;
  assign ll_waddr = head_pl.waddr;
  assign ll_wdata = head_pl.wdata;

  // Misaligned responses never reach the FIFO, so they cannot also overflow.
  always_comb begin
    err_overflow_d = err_overflow_q | (enq_val & ~enq_rdy_c);
    err_misalign_d = err_misalign_q | (dmem_resp_val & resp_misal);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow_q <= 1'b0;
      err_misalign_q <= 1'b0;
    end else begin
      err_overflow_q <= err_overflow_d;
      err_misalign_q <= err_misalign_d;
    end
  end

  assign err_overflow = err_overflow_q;
  assign err_misalign = err_misalign_q;

endmodule

// File: doc/riscv_dmem_resp_align.md
RISCV_DMEM_RESP_ALIGN -- requirements
Module: riscv_dmem_resp_align

Interface
REQ-001 Parameter DEPTH, default 4, number of response buffer entries; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dmem_resp_val  input  1  data memory response valid; no back-pressure toward memory.
REQ-005 dmem_resp_data  input  64  raw aligned doubleword from data memory.
REQ-006 dmem_resp_tag  input  12  tag[11]=fp, tag[10:8]=type, tag[7:5]=byte offset, tag[4:0]=dest reg.
REQ-007 ll_val  output  1  aligned load result valid toward writeback.
REQ-008 ll_rdy  input  1  writeback accepts the result this cycle.
REQ-009 ll_waddr  output  5  destination register.
REQ-010 ll_wdata  output  64  extended load data.
REQ-011 ll_fp  output  1  result targets the FP register file.
REQ-012 err_overflow  output  1  sticky: a response arrived while the buffer was full.
REQ-013 err_misalign  output  1  sticky: offset not aligned to access size, or FP byte/halfword type.
REQ-014 count  output  log2(DEPTH)+1  current buffer occupancy.

Function
REQ-015 Type codes: B=000, H=001, W=010, D=011, BU=100, HU=101, WU=110; 111 SHALL be treated as misaligned.
REQ-016 Extraction: field = data >> (8*offset) truncated to 8/16/32/64 bits; B/H/W sign-extend; BU/HU/WU/D zero-extend to 64.
REQ-017 FP W loads SHALL zero-extend (raw bits passed unrecoded); FP D passes 64 bits unchanged.
REQ-018 Alignment: H requires offset[0]=0, W/WU offset[1:0]=0, D offset=0; a violating response is dropped and sets err_misalign.
REQ-019 Alignment and extension are computed combinationally on the input; the aligned result is written into a DEPTH-entry FIFO.
REQ-020 Latency: a response valid at cycle N with an empty FIFO SHALL appear on ll_val/ll_* at cycle N+1; no combinational input-to-output path.
REQ-021 Outputs are driven from the FIFO head; ll_val = (count != 0); dequeue occurs when ll_val & ll_rdy.
REQ-022 While ll_val=1 and ll_rdy=0, ll_waddr/ll_wdata/ll_fp SHALL hold stable.
REQ-023 Full: when count=DEPTH and no dequeue this cycle, an arriving response is dropped and err_overflow is set; FIFO contents are unchanged.
REQ-024 Simultaneous enqueue and dequeue at count=DEPTH SHALL succeed (count unchanged, no overflow).
REQ-025 Simultaneous enqueue and dequeue at count=0 is impossible by REQ-020; an enqueue at count=0 yields count=1.
REQ-026 Pointers wrap modulo DEPTH; responses SHALL leave in arrival order.
REQ-027 err_overflow and err_misalign are cleared only by reset.

Reset
REQ-028 On reset: count=0, read/write pointers=0, ll_val=0, err_overflow=0, err_misalign=0; FIFO data need not be cleared.
REQ-029 A response arriving in a reset cycle SHALL be discarded; a response in flight at reset is lost.
REQ-030 ll_waddr/ll_wdata/ll_fp are don't-care while ll_val=0.

Structure
REQ-031 Type codes, tag field positions and tag width SHALL live in the shared riscv constants header.
REQ-032 The FIFO SHALL be a sub-module riscv_resp_fifo (parameterised width/depth, val/rdy on both sides, count output); alignment logic stays in the top.

Verification
REQ-033 Tag {fp=0,B,off=3,rd=5}, data 0x0000_0000_8000_0000 -> cycle N+1: ll_waddr=5, ll_wdata=0xFFFF_FFFF_FFFF_FF80.
REQ-034 Tag {fp=0,WU,off=4,rd=9}, data 0x8765_4321_0000_0000 -> ll_wdata=0x0000_0000_8765_4321; same with W -> 0xFFFF_FFFF_8765_4321.
REQ-035 Hold ll_rdy=0, send 5 responses (DEPTH=4) -> count=4, err_overflow=1, then release -> first 4 emerge in order, 5th absent.
REQ-036 Tag {H,off=1} and tag {fp=1,B,off=0} -> no ll_val, err_misalign=1, count stays 0.
REQ-037 At count=4, ll_rdy=1 with simultaneous response -> count stays 4, err_overflow=0, new entry emerges last.
REQ-038 Assert reset with count=3 -> next cycle ll_val=0, count=0, both error flags 0.
